// File: rtl/scan_frame_tx.sv
// scan_frame_tx: framed serial scan-out of one selected debug channel.
// A frame is a sync header, then the snapshotted data word, then an optional
// parity bit. Holding en high streams frames back-to-back with no gap.
// Optional feature macro: SCAN_PARITY_EN appends an even-parity bit to each frame.
module scan_frame_tx #(
  parameter int                DATA_W   = 19,
  parameter int                N_CH     = 1,
  parameter int                SYNC_W   = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1011,
  localparam int               CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [CH_W-1:0]        ch_sel,
  input  logic                   msb_first,
  input  logic [N_CH*DATA_W-1:0] scan_data,
  output logic                   scan_out,
  output logic                   scan_valid,
  output logic                   busy,
  output logic                   done
);

  localparam int MAXW  = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int CNT_W = $clog2(MAXW + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_DATA = 2'd2
`ifdef SCAN_PARITY_EN
    ,S_PAR = 2'd3
`endif
  } state_t;

  state_t              state_q;
  logic                last_en_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   shreg_q;
  logic [SYNC_W-1:0]   sync_q;
  logic                msb_q;
  logic                done_q;
`ifdef SCAN_PARITY_EN
  logic                par_q;
`endif

  logic [DATA_W-1:0]   snap_d;
  logic                start;
  logic                last_bit;
  logic                unused_ch;

  // ch_sel has no effect with a single channel; fold it so it is not dangling.
  assign unused_ch = ^ch_sel;

  // Channel mux; out-of-range selects fall back to channel 0.
  always_comb begin
    snap_d = scan_data[DATA_W-1:0];
    for (int c = 1; c < N_CH; c++)
      if (ch_sel == CH_W'(c)) snap_d = scan_data[c*DATA_W +: DATA_W];
  end

  assign start = en & ~last_en_q & (state_q == S_IDLE);

  // Last serial bit of the frame: parity slot if present, else final data bit.
`ifdef SCAN_PARITY_EN
  assign last_bit = (state_q == S_PAR);
`else
  assign last_bit = (state_q == S_DATA) && (cnt_q == CNT_W'(DATA_W - 1));
`endif

  // Frame sequencer: snapshot on start or continuous restart, then walk header/data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_en_q <= 1'b0;
      cnt_q     <= '0;
      shreg_q   <= '0;
      sync_q    <= '0;
      msb_q     <= 1'b0;
      done_q    <= 1'b0;
`ifdef SCAN_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      last_en_q <= en;
      done_q    <= last_bit;
      if (start || (last_bit && en)) begin
        state_q <= S_SYNC;
        cnt_q   <= '0;
        shreg_q <= snap_d;
        sync_q  <= SYNC_PAT;
        msb_q   <= msb_first;
`ifdef SCAN_PARITY_EN
        par_q   <= ^snap_d;
`endif
      end else begin
        case (state_q)
          S_SYNC: begin
            sync_q <= sync_q << 1;
            if (cnt_q == CNT_W'(SYNC_W - 1)) begin
              state_q <= S_DATA;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_DATA: begin
            shreg_q <= msb_q ? (shreg_q << 1) : (shreg_q >> 1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
`ifdef SCAN_PARITY_EN
              state_q <= S_PAR;
`else
              state_q <= S_IDLE;
`endif
              cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
`ifdef SCAN_PARITY_EN
          S_PAR: state_q <= S_IDLE;
`endif
          default: ;
        endcase
      end
    end
  end

  // Serial bit decoded purely from registered state.
  always_comb begin
    scan_out = 1'b0;
    case (state_q)
      S_SYNC: scan_out = sync_q[SYNC_W-1];
      S_DATA: scan_out = msb_q ? shreg_q[DATA_W-1] : shreg_q[0];
`ifdef SCAN_PARITY_EN
      S_PAR:  scan_out = par_q;
`endif
      default: scan_out = 1'b0;
    endcase
  end

  assign scan_valid = (state_q != S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;

endmodule
